mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Two-requester arbiter and sequencer for the 128x8 RAM block. It shares the single memory port between the instruction-fetch path (read-only) and the load/store data path (read/write). It drives the RAM's en/read/write/address/input_data, waits for the RAM's ready, returns read data, and recovers from a RAM that never signals ready. It sits between the CPU control unit and the RAM.

Parameters:
ADDR_W, 8, width of address bus (RAM uses low 7 bits; bit 7 passed through unchanged).
DATA_W, 8, data width.
TIMEOUT, 15, max cycles in ACCESS with mem_ready low before abort (range 1..255).

Ports:
clk  in  1  system clock, all logic on posedge.
reset  in  1  synchronous, active-high reset.
f_req  in  1  fetch request; held high with f_addr stable until f_ack.
f_addr  in  ADDR_W  fetch address.
f_ack  out  1  one-cycle completion pulse for fetch.
f_rdata  out  DATA_W  fetched byte, valid when f_ack=1, held until next f_ack.
d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ack.
d_we  in  1  1=store, 0=load.
d_addr  in  ADDR_W  data address.
d_wdata  in  DATA_W  store data.
d_ack  out  1  one-cycle completion pulse for data access.
d_rdata  out  DATA_W  load result, valid when d_ack=1 and d_we was 0.
err  out  1  pulses with the ack of an aborted (timed-out) access.
busy  out  1  high in ACCESS and RELEASE.
mem_en  out  1  RAM enable.
mem_read  out  1  RAM read strobe.
mem_write  out  1  RAM write strobe.
mem_address  out  ADDR_W  RAM address.
mem_input_data  out  DATA_W  RAM write data.
mem_output_data  in  DATA_W  RAM read data.
mem_ready  in  1  RAM ready.

Behaviour:
- Reset (sync): state=IDLE; all outputs 0 (mem_*, acks, rdata, err, busy); last_grant=FETCH; timeout count=0. Reset mid-access drops the request with no ack; a store may already be committed in the RAM.
- All outputs are registered.
- IDLE: if no req, stay. If one req, grant it. If both, grant the one not equal to last_grant (round-robin; first tie after reset goes to data). On grant, latch op/addr/wdata; next cycle mem_en=1, mem_read=!we, mem_write=we (fetch always read), mem_address/mem_input_data from the latch; update last_grant; go ACCESS.
- ACCESS: hold all mem_* stable. Each cycle with mem_ready=0, increment count.
  - If mem_ready=1 sampled: capture mem_output_data into the granted port's rdata (reads only; rdata is unchanged for stores); assert that port's ack for exactly one cycle; drop mem_en/read/write; go RELEASE.
  - If count reaches TIMEOUT with mem_ready still 0: ack with err=1, rdata unchanged, drop mem_en; go RELEASE.
- RELEASE: mem_en=0 for exactly one cycle, which clears the RAM's internal counter; go IDLE. Requests are not sampled in RELEASE.
- Latency with the current RAM (ready on the 2nd enabled edge): req seen at edge 0 -> mem_en high after edge 0 -> mem_ready high after edge 2 -> ack high after edge 3. Minimum 4 cycles req-to-ack; 5-cycle repeat rate per port.
- A requester that still holds req in the cycle after its ack issues a new access.
- mem_read and mem_write are never high together. mem_en is never high in IDLE or RELEASE.

Decomposition:
- Shared package mem_pkg: state encoding (IDLE=2'd0, ACCESS=2'd1, RELEASE=2'd2), requester IDs (GNT_FETCH=1'b0, GNT_DATA=1'b1), DATA_W/ADDR_W defaults. The ISA opcode/register constants move into the same package for benches.
- One sub-module: mem_watchdog (load/clear, count-enable, expired flag at TIMEOUT).

Test Plan:
- Preload RAM[12]=8'hAB; f_req with f_addr=12 -> f_ack 4 cycles after req, f_rdata=8'hAB, err=0, mem_write never 1.
- d_req store d_addr=40, d_wdata=8'h5A, then d_req load 40 -> d_ack each, second d_rdata=8'h5A; f_rdata untouched.
- f_req and d_req raised the same cycle after reset, addresses 13 (8'hE8) and 7 (8'h20) -> data served first (d_rdata=8'h20), then fetch (f_rdata=8'hE8); mem_en low one cycle between.
- Both reqs held high continuously for 4 grants -> grants alternate D,F,D,F; each ack a single-cycle pulse.
- RAM model with ready tied 0, TIMEOUT=15, fetch addr 3 -> f_ack and err high together 16 cycles after mem_en rises; mem_en low next cycle; f_rdata unchanged.
- reset asserted during ACCESS of store addr 50 -> next cycle all outputs 0, no d_ack; following fetch completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory arbiter and the CPU-side benches.
// State encoding, requester IDs, bus width defaults and the round-robin pick.
package mem_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } gnt_t;

  // ISA opcode and register constants shared with the CPU control unit benches
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_JMP   = 4'h5;
  localparam logic [3:0] OP_JZ    = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'hF;
  localparam logic [1:0] REG_A    = 2'd0;
  localparam logic [1:0] REG_B    = 2'd1;
  localparam logic [1:0] REG_PC   = 2'd2;
  localparam logic [1:0] REG_IR   = 2'd3;

  // On a tie the requester that was not served last wins.
  function automatic gnt_t next_grant(input logic f_req, input logic d_req,
                                      input gnt_t last);
    gnt_t g;
    if (f_req && d_req) g = (last == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
    else if (d_req)     g = GNT_DATA;
    else                g = GNT_FETCH;
    return g;
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Cycle counter guarding a RAM access; flags expiry once TIMEOUT stalled
// cycles have been counted.
module mem_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] TC = 8'(TIMEOUT);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)     count_d = 8'd0;
    else if (en_i) count_d = count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= 8'd0;
    else       count_q <= count_d;
  end

  assign expired_o = (count_q == TC);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM port between instruction fetch and
// load/store, with ready handshake, one-cycle release and stall timeout.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_input_data,
  input  logic [DATA_W-1:0] mem_output_data,
  input  logic              mem_ready
);

  arb_state_t state_q, state_d;
  gnt_t       last_q, last_d;
  gnt_t       gnt_q, gnt_d;

  logic              mem_en_q, mem_en_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_input_data_q, mem_input_data_d;
  logic              f_ack_q, f_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic wd_clr, wd_cnt_en, wd_expired;

  mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (wd_clr),
    .en_i      (wd_cnt_en),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d          = state_q;
    last_d           = last_q;
    gnt_d            = gnt_q;
    mem_en_d         = mem_en_q;
    mem_read_d       = mem_read_q;
    mem_write_d      = mem_write_q;
    mem_address_d    = mem_address_q;
    mem_input_data_d = mem_input_data_q;
    f_ack_d          = 1'b0;
    d_ack_d          = 1'b0;
    f_rdata_d        = f_rdata_q;
    d_rdata_d        = d_rdata_q;
    err_d            = 1'b0;
    busy_d           = busy_q;
    wd_clr           = 1'b0;
    wd_cnt_en        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (f_req || d_req) begin
          gnt_d    = next_grant(f_req, d_req, last_q);
          last_d   = gnt_d;
          wd_clr   = 1'b1;
          mem_en_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = ACCESS;
          if (gnt_d == GNT_DATA) begin
            mem_read_d       = !d_we;
            mem_write_d      = d_we;
            mem_address_d    = d_addr;
            mem_input_data_d = d_wdata;
          end else begin
            mem_read_d    = 1'b1;
            mem_write_d   = 1'b0;
            mem_address_d = f_addr;
          end
        end
      end

      ACCESS: begin
        // ready wins over a timeout landing on the same cycle
        if (mem_ready || wd_expired) begin
          if (gnt_q == GNT_DATA) d_ack_d = 1'b1;
          else                   f_ack_d = 1'b1;
          if (!mem_ready)        err_d   = 1'b1;
          else if (mem_read_q) begin
            if (gnt_q == GNT_DATA) d_rdata_d = mem_output_data;
            else                   f_rdata_d = mem_output_data;
          end
          mem_en_d    = 1'b0;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = RELEASE;
        end else begin
          wd_cnt_en = 1'b1;
        end
      end

      RELEASE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        mem_en_d    = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      last_q           <= GNT_FETCH;
      gnt_q            <= GNT_FETCH;
      mem_en_q         <= 1'b0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_address_q    <= '0;
      mem_input_data_q <= '0;
      f_ack_q          <= 1'b0;
      d_ack_q          <= 1'b0;
      f_rdata_q        <= '0;
      d_rdata_q        <= '0;
      err_q            <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      last_q           <= last_d;
      gnt_q            <= gnt_d;
      mem_en_q         <= mem_en_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
      mem_address_q    <= mem_address_d;
      mem_input_data_q <= mem_input_data_d;
      f_ack_q          <= f_ack_d;
      d_ack_q          <= d_ack_d;
      f_rdata_q        <= f_rdata_d;
      d_rdata_q        <= d_rdata_d;
      err_q            <= err_d;
      busy_q           <= busy_d;
    end
  end

  assign mem_en         = mem_en_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_address    = mem_address_q;
  assign mem_input_data = mem_input_data_q;
  assign f_ack          = f_ack_q;
  assign d_ack          = d_ack_q;
  assign f_rdata        = f_rdata_q;
  assign d_rdata        = d_rdata_q;
  assign err            = err_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a 128x8 RAM model with ready on the
// second enabled edge, directed scenarios, then random traffic on both ports.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       f_req = 1'b0;
  logic [7:0] f_addr = '0;
  logic       f_ack;
  logic [7:0] f_rdata;
  logic       d_req = 1'b0;
  logic       d_we = 1'b0;
  logic [7:0] d_addr = '0;
  logic [7:0] d_wdata = '0;
  logic       d_ack;
  logic [7:0] d_rdata;
  logic       err;
  logic       busy;
  logic       mem_en, mem_read, mem_write;
  logic [7:0] mem_address, mem_input_data;
  logic [7:0] mem_output_data;
  logic       mem_ready;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .err(err), .busy(busy),
    .mem_en(mem_en), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_input_data(mem_input_data),
    .mem_output_data(mem_output_data), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input bit ok, input string name,
                     input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] init_val(input int i);
    logic [7:0] v;
    v = 8'(i * 37 + 5);
    if (i == 12) v = 8'hAB;
    if (i == 13) v = 8'hE8;
    if (i == 7)  v = 8'h20;
    return v;
  endfunction

  // RAM model: ready pulses on the second consecutive enabled edge.
  logic [7:0] ram [128];
  bit hang = 1'b0;
  initial begin
    int rcnt;
    rcnt = 0;
    for (int i = 0; i < 128; i++) ram[i] = init_val(i);
    mem_ready = 1'b0;
    mem_output_data = '0;
    forever begin
      @(posedge clk);
      if (!mem_en) begin
        rcnt = 0;
        mem_ready <= 1'b0;
      end else begin
        if (rcnt == 1 && !hang) begin
          mem_ready <= 1'b1;
          if (mem_write) ram[mem_address[6:0]] = mem_input_data;
          else           mem_output_data <= ram[mem_address[6:0]];
        end else begin
          mem_ready <= 1'b0;
        end
        if (rcnt < 1000) rcnt++;
      end
    end
  end

  // Reference model state
  typedef struct { logic [7:0] rdata; logic err; } exp_t;
  exp_t fq[$];
  exp_t dq[$];
  logic [7:0] shadow [128];
  logic [7:0] exp_f_last = '0;
  logic [7:0] exp_d_last = '0;
  int glog[$];

  // Monitor
  bit mon_en = 1'b0;
  bit prev_f_ack = 1'b0, prev_d_ack = 1'b0, prev_en = 1'b0;
  bit saw_write = 1'b0;
  int en_rise_cyc = 0;

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk(!(mem_read && mem_write), "rd_wr_exclusive", {mem_read, mem_write}, 64'h0);
      chk(!mem_en || busy, "en_implies_busy", {mem_en, busy}, 64'h3);
      chk(!err || f_ack || d_ack, "err_only_with_ack", {err, f_ack, d_ack}, 64'h0);
      if (mem_write) saw_write = 1'b1;
      if (mem_en && !prev_en) en_rise_cyc = cyc;
      if (f_ack) begin
        chk(!prev_f_ack, "f_ack_single_pulse", 64'(prev_f_ack), 64'h0);
        if (fq.size() == 0) chk(1'b0, "f_ack_unexpected", 64'(f_ack), 64'h0);
        else begin
          e = fq.pop_front();
          chk(f_rdata == e.rdata, "f_rdata", 64'(f_rdata), 64'(e.rdata));
          chk(err == e.err, "f_err", 64'(err), 64'(e.err));
        end
        glog.push_back(0);
      end
      if (d_ack) begin
        chk(!prev_d_ack, "d_ack_single_pulse", 64'(prev_d_ack), 64'h0);
        if (dq.size() == 0) chk(1'b0, "d_ack_unexpected", 64'(d_ack), 64'h0);
        else begin
          e = dq.pop_front();
          chk(d_rdata == e.rdata, "d_rdata", 64'(d_rdata), 64'(e.rdata));
          chk(err == e.err, "d_err", 64'(err), 64'(e.err));
        end
        glog.push_back(1);
      end
    end
    prev_f_ack = f_ack;
    prev_d_ack = d_ack;
    prev_en    = mem_en;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    f_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    chk({mem_en, mem_read, mem_write, mem_address, mem_input_data, f_ack, d_ack,
         f_rdata, d_rdata, err, busy} == '0, "reset_outputs",
        64'({mem_en, mem_read, mem_write, mem_address, mem_input_data, f_ack, d_ack,
             f_rdata, d_rdata, err, busy}), 64'h0);
    reset = 1'b0;
    fq.delete();
    dq.delete();
    glog.delete();
    exp_f_last = '0;
    exp_d_last = '0;
    mon_en = 1'b1;
  endtask

  task automatic fetch_acc(input logic [7:0] a, input bit hold, input bit exp_err,
                           output int req_cyc, output int ack_cyc);
    bit got;
    @(negedge clk);
    f_req = 1'b1;
    f_addr = a;
    req_cyc = cyc;
    if (exp_err) fq.push_back('{exp_f_last, 1'b1});
    else begin
      exp_f_last = shadow[a[6:0]];
      fq.push_back('{exp_f_last, 1'b0});
    end
    got = 1'b0;
    ack_cyc = -1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (f_ack) begin got = 1'b1; ack_cyc = cyc; end
    end
    if (!got) chk(1'b0, "f_ack_timeout", 64'h0, 64'h1);
    if (!hold) begin
      @(negedge clk);
      f_req = 1'b0;
    end
  endtask

  task automatic data_acc(input bit we, input logic [7:0] a, input logic [7:0] wd,
                          input bit hold, output int ack_cyc);
    bit got;
    @(negedge clk);
    d_req = 1'b1;
    d_we = we;
    d_addr = a;
    d_wdata = wd;
    if (we) begin
      shadow[a[6:0]] = wd;
      dq.push_back('{exp_d_last, 1'b0});
    end else begin
      exp_d_last = shadow[a[6:0]];
      dq.push_back('{exp_d_last, 1'b0});
    end
    got = 1'b0;
    ack_cyc = -1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (d_ack) begin got = 1'b1; ack_cyc = cyc; end
    end
    if (!got) chk(1'b0, "d_ack_timeout", 64'h0, 64'h1);
    if (!hold) begin
      @(negedge clk);
      d_req = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    int rc, fa, da, fa2, da2;
    bit gotit;
    for (int i = 0; i < 128; i++) shadow[i] = init_val(i);
    repeat (3) @(negedge clk);
    do_reset();

    // Single fetch: 4-cycle latency, no write strobe
    saw_write = 1'b0;
    fetch_acc(8'd12, 1'b0, 1'b0, rc, fa);
    chk(fa - rc == 4, "fetch_latency", 64'(fa - rc), 64'd4);
    chk(f_rdata == 8'hAB, "fetch_12_data", 64'(f_rdata), 64'hAB);
    chk(!saw_write, "fetch_no_write", 64'(saw_write), 64'h0);

    // Store then load on the data port
    data_acc(1'b1, 8'd40, 8'h5A, 1'b0, da);
    data_acc(1'b0, 8'd40, 8'h00, 1'b0, da);
    chk(d_rdata == 8'h5A, "load_after_store", 64'(d_rdata), 64'h5A);
    chk(f_rdata == exp_f_last, "f_rdata_untouched", 64'(f_rdata), 64'(exp_f_last));

    // Simultaneous requests after reset: data first, then fetch
    do_reset();
    glog.delete();
    fork
      fetch_acc(8'd13, 1'b0, 1'b0, rc, fa);
      data_acc(1'b0, 8'd7, 8'h00, 1'b0, da);
    join
    chk(fa - da == 5, "tie_ack_spacing", 64'(fa - da), 64'd5);
    chk(glog.size() == 2 && glog[0] == 1 && glog[1] == 0, "tie_order",
        64'(glog.size() > 1 ? {glog[0][3:0], glog[1][3:0]} : 8'hFF), 64'h10);
    chk(d_rdata == 8'h20 && f_rdata == 8'hE8, "tie_data",
        64'({d_rdata, f_rdata}), 64'h20E8);

    // Both held for four grants: D,F,D,F
    do_reset();
    glog.delete();
    fork
      begin
        fetch_acc(8'd13, 1'b1, 1'b0, rc, fa);
        fetch_acc(8'd12, 1'b0, 1'b0, rc, fa2);
      end
      begin
        data_acc(1'b0, 8'd7, 8'h00, 1'b1, da);
        data_acc(1'b0, 8'd40, 8'h00, 1'b0, da2);
      end
    join
    chk(glog.size() == 4, "rr_grant_count", 64'(glog.size()), 64'd4);
    if (glog.size() == 4)
      chk(glog[0] == 1 && glog[1] == 0 && glog[2] == 1 && glog[3] == 0, "rr_alternation",
          64'({glog[0][3:0], glog[1][3:0], glog[2][3:0], glog[3][3:0]}), 64'h1010);
    chk(fa2 - da2 == 5 && da2 - fa == 5 && fa - da == 5, "rr_spacing",
        64'({16'(fa - da), 16'(da2 - fa), 16'(fa2 - da2)}), 64'h000500050005);

    // Stalled RAM: abort with err after TIMEOUT+1 enabled cycles
    hang = 1'b1;
    fetch_acc(8'd3, 1'b0, 1'b1, rc, fa);
    chk(fa - en_rise_cyc == 16, "timeout_latency", 64'(fa - en_rise_cyc), 64'd16);
    hang = 1'b0;
    @(negedge clk);
    chk(!mem_en && !mem_read, "timeout_release", 64'({mem_en, mem_read}), 64'h0);

    // Reset in the middle of a store
    do_reset();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'd50; d_wdata = 8'hC3;
    gotit = 1'b0;
    for (int i = 0; i < 20 && !gotit; i++) begin
      @(negedge clk);
      if (mem_en) gotit = 1'b1;
    end
    chk(gotit, "store_started", 64'(gotit), 64'h1);
    reset = 1'b1;
    d_req = 1'b0;
    @(negedge clk);
    chk({mem_en, mem_read, mem_write, mem_address, mem_input_data, f_ack, d_ack,
         f_rdata, d_rdata, err, busy} == '0, "reset_mid_access",
        64'({mem_en, mem_write, mem_address, d_ack, busy}), 64'h0);
    reset = 1'b0;
    exp_f_last = '0;
    exp_d_last = '0;
    fetch_acc(8'd12, 1'b0, 1'b0, rc, fa);
    chk(fa - rc == 4, "fetch_after_reset", 64'(fa - rc), 64'd4);

    // Random traffic on both ports
    do_reset();
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          logic [7:0] a;
          bit h;
          a = {1'($urandom), 1'b0, 6'($urandom)};
          h = (k == 29) ? 1'b0 : 1'($urandom);
          fetch_acc(a, h, 1'b0, rc, fa);
          if (!h) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
      begin
        for (int k = 0; k < 30; k++) begin
          logic [7:0] a;
          bit we, h;
          int dac;
          we = 1'($urandom);
          a = we ? {1'($urandom), 1'b1, 6'($urandom)} : {1'($urandom), 7'($urandom)};
          h = (k == 29) ? 1'b0 : 1'($urandom);
          data_acc(we, a, 8'($urandom), h, dac);
          if (!h) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
    join

    repeat (4) @(negedge clk);
    chk(fq.size() == 0 && dq.size() == 0, "scoreboard_drained",
        64'(fq.size() + dq.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
